// File: rtl/vdc_htiming_detect.sv
// vdc_htiming_detect: measures horizontal video timing (line length, sync width,
// back porch, active width) from hsync/hblank and reports when it is stable.
`default_nettype none

module vdc_htiming_detect #(
   parameter int CNT_W        = 12,
   parameter int STABLE_LINES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             hsync,
   input  logic             hblank,
   output logic [CNT_W-1:0] line_total,
   output logic [CNT_W-1:0] sync_width,
   output logic [CNT_W-1:0] back_porch,
   output logic [CNT_W-1:0] active_width,
   output logic             newLine,
   output logic             meas_valid,
   output logic             stable,
   output logic             overflow
);

   localparam logic [0:0]       SEEK      = 1'b0;
   localparam logic [0:0]       MEASURE   = 1'b1;
   localparam logic [CNT_W-1:0] POS_MAX   = {CNT_W{1'b1}};
   localparam logic [3:0]       MATCH_SAT = 4'(STABLE_LINES);

   logic [0:0]       state;
   logic             hs_d;
   logic             hb_d;
   logic [CNT_W-1:0] pos;
   logic [CNT_W-1:0] sw_acc;
   logic [CNT_W-1:0] aw_acc;
   logic [CNT_W-1:0] bp_acc;
   logic             bp_found;
   logic [3:0]       match_cnt;

   logic             rise;
   logic             hb_fall;
   logic [CNT_W-1:0] pos_inc;

   assign rise    = enable & hsync & ~hs_d;
   assign hb_fall = enable & ~hblank & hb_d;
   assign pos_inc = pos + 1'b1;
   assign stable  = (match_cnt == MATCH_SAT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= SEEK;
         hs_d         <= 1'b0;
         hb_d         <= 1'b0;
         pos          <= '0;
         sw_acc       <= '0;
         aw_acc       <= '0;
         bp_acc       <= '0;
         bp_found     <= 1'b0;
         match_cnt    <= '0;
         line_total   <= '0;
         sync_width   <= '0;
         back_porch   <= '0;
         active_width <= '0;
         newLine      <= 1'b0;
         meas_valid   <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         newLine <= 1'b0;
         if (enable) begin
            hs_d <= hsync;
            hb_d <= hblank;
            if (rise) begin
               if (state == MEASURE) begin
                  line_total   <= pos_inc;
                  sync_width   <= sw_acc;
                  back_porch   <= bp_acc;
                  active_width <= aw_acc;
                  newLine      <= 1'b1;
                  meas_valid   <= 1'b1;
                  overflow     <= 1'b0;
                  if ((pos_inc == line_total) && (sw_acc == sync_width)) begin
                     if (match_cnt != MATCH_SAT)
                        match_cnt <= match_cnt + 4'd1;
                  end else begin
                     match_cnt <= '0;
                  end
               end
               // The rise sample is the first sample of the new line.
               state    <= MEASURE;
               pos      <= '0;
               sw_acc   <= CNT_W'(1);
               aw_acc   <= {{(CNT_W-1){1'b0}}, ~hblank};
               bp_acc   <= '0;
               bp_found <= hb_fall;
            end else if (state == MEASURE) begin
               pos <= pos_inc;
               if (hsync)
                  sw_acc <= sw_acc + 1'b1;
               if (!hblank)
                  aw_acc <= aw_acc + 1'b1;
               if (hb_fall && !bp_found) begin
                  bp_acc   <= pos_inc;
                  bp_found <= 1'b1;
               end
               // Line too long to measure: abandon and resynchronise.
               if (pos_inc == POS_MAX) begin
                  overflow   <= 1'b1;
                  meas_valid <= 1'b0;
                  match_cnt  <= '0;
                  state      <= SEEK;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vdc_htiming_detect.sv
// tb_vdc_htiming_detect: directed table-driven checks of the horizontal timing detector.
`default_nettype none

module tb_vdc_htiming_detect;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        hsync = 1'b0;
   logic        hblank = 1'b0;
   logic [11:0] line_total, sync_width, back_porch, active_width;
   logic        newLine, meas_valid, stable, overflow;

   int n_chk = 0;
   int n_err = 0;
   int nl_cnt = 0;
   bit half = 1'b0;

   // Snapshots taken right after the first (rise) sample of a line.
   int s_nl, s_lt, s_sw, s_bp, s_aw, s_stb, s_vld, s_ovf, s_nl2;

   vdc_htiming_detect #(.CNT_W(12), .STABLE_LINES(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .hsync(hsync), .hblank(hblank),
      .line_total(line_total), .sync_width(sync_width), .back_porch(back_porch),
      .active_width(active_width), .newLine(newLine), .meas_valid(meas_valid),
      .stable(stable), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (newLine === 1'b1) nl_cnt++;

   typedef struct {
      int len; int sw; int hbh;
      int pub; int lt; int swo; int bp; int aw; int stb; int vld;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic hs, input logic hb);
      hsync = hs; hblank = hb; enable = 1'b1;
      @(posedge clk); #1;
      if (half) begin
         enable = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   // hblank is high for samples k < hbh and k >= hbe.
   task automatic send_line(input int len, input int sw, input int hbh, input int hbe);
      hsync = 1'b1; hblank = (0 < hbh) || (0 >= hbe); enable = 1'b1;
      @(posedge clk); #1;
      s_nl = newLine; s_lt = line_total; s_sw = sync_width; s_bp = back_porch;
      s_aw = active_width; s_stb = stable; s_vld = meas_valid; s_ovf = overflow;
      s_nl2 = 0;
      if (half) begin
         enable = 1'b0;
         @(posedge clk); #1;
         s_nl2 = newLine;
      end
      for (int k = 1; k < len; k++) tick(k < sw, (k < hbh) || (k >= hbe));
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1; enable = 1'b0; hsync = 1'b0; hblank = 1'b0;
      @(posedge clk); #1;
      check({tag, "_rst_outs"},
            int'({line_total, sync_width, back_porch, active_width}) |
            int'({newLine, meas_valid, stable, overflow}), 0);
      reset = 1'b0;
   endtask

   initial begin
      int base;
      int first_ovf;
      int vld_at_ovf;

      //         len  sw  hbh pub lt    sw  bp   aw   stb vld
      tbl[0]  = '{1024, 72, 160, 0, 0,    0,  0,   0,   0, 0};
      tbl[1]  = '{1024, 72, 160, 1, 1024, 72, 160, 864, 0, 1};
      tbl[2]  = '{1024, 72, 160, 1, 1024, 72, 160, 864, 0, 1};
      tbl[3]  = '{1024, 72, 160, 1, 1024, 72, 160, 864, 0, 1};
      tbl[4]  = '{1024, 72, 160, 1, 1024, 72, 160, 864, 0, 1};
      tbl[5]  = '{1016, 72, 160, 1, 1024, 72, 160, 864, 1, 1};
      tbl[6]  = '{1024, 72, 160, 1, 1016, 72, 160, 856, 0, 1};
      tbl[7]  = '{1024, 72, 160, 1, 1024, 72, 160, 864, 0, 1};
      tbl[8]  = '{1024, 72, 160, 1, 1024, 72, 160, 864, 0, 1};
      tbl[9]  = '{1024, 72, 160, 1, 1024, 72, 160, 864, 0, 1};
      tbl[10] = '{1024, 72, 160, 1, 1024, 72, 160, 864, 0, 1};
      tbl[11] = '{1024, 72, 160, 1, 1024, 72, 160, 864, 1, 1};

      repeat (2) @(posedge clk);
      #1;
      do_reset("init");

      // Full-rate stream with a single short line.
      base = nl_cnt;
      for (int i = 0; i < 12; i++) begin
         send_line(tbl[i].len, tbl[i].sw, tbl[i].hbh, tbl[i].len);
         check($sformatf("t%0d_newLine", i), s_nl, tbl[i].pub);
         check($sformatf("t%0d_valid", i), s_vld, tbl[i].vld);
         check($sformatf("t%0d_stable", i), s_stb, tbl[i].stb);
         check($sformatf("t%0d_line_total", i), s_lt, tbl[i].lt);
         check($sformatf("t%0d_sync_width", i), s_sw, tbl[i].swo);
         check($sformatf("t%0d_back_porch", i), s_bp, tbl[i].bp);
         check($sformatf("t%0d_active_width", i), s_aw, tbl[i].aw);
      end
      check("full_rate_newLine_count", nl_cnt - base, 11);

      // Enable every second clock.
      do_reset("half");
      half = 1'b1;
      base = nl_cnt;
      for (int i = 0; i < 3; i++) send_line(1024, 72, 160, 1024);
      half = 1'b0;
      check("half_newLine", s_nl, 1);
      check("half_newLine_gone", s_nl2, 0);
      check("half_line_total", s_lt, 1024);
      check("half_sync_width", s_sw, 72);
      check("half_back_porch", s_bp, 160);
      check("half_active_width", s_aw, 864);
      check("half_newLine_count", nl_cnt - base, 2);

      // Overflow on a missing hsync, then recovery.
      do_reset("ovf");
      send_line(100, 10, 20, 100);
      send_line(100, 10, 20, 100);
      tick(1'b1, 1'b1);
      check("ovf_pre_valid", int'(meas_valid), 1);
      first_ovf = -1;
      vld_at_ovf = -1;
      for (int j = 1; j < 5000; j++) begin
         tick(1'b0, 1'b1);
         if (first_ovf < 0 && overflow === 1'b1) begin
            first_ovf = j;
            vld_at_ovf = meas_valid;
         end
      end
      check("ovf_sample", first_ovf, 4095);
      check("ovf_valid_cleared", vld_at_ovf, 0);
      check("ovf_stable", int'(stable), 0);
      send_line(100, 10, 20, 100);
      check("ovf_seek_rise_newLine", s_nl, 0);
      check("ovf_seek_rise_overflow", s_ovf, 1);
      send_line(100, 10, 20, 100);
      check("ovf_recover_newLine", s_nl, 1);
      check("ovf_recover_overflow", s_ovf, 0);
      check("ovf_recover_valid", s_vld, 1);
      check("ovf_recover_line_total", s_lt, 100);
      check("ovf_recover_back_porch", s_bp, 20);
      check("ovf_recover_active_width", s_aw, 80);

      // hblank falls on the hsync rise, then hblank never low.
      do_reset("hb");
      for (int i = 0; i < 3; i++) send_line(100, 10, 0, 90);
      check("coinc_back_porch", s_bp, 0);
      check("coinc_active_width", s_aw, 90);
      check("coinc_sync_width", s_sw, 10);
      send_line(100, 10, 100, 100);
      send_line(100, 10, 100, 100);
      check("noact_back_porch", s_bp, 0);
      check("noact_active_width", s_aw, 0);
      check("noact_line_total", s_lt, 100);

      // Reset in the middle of a line.
      for (int i = 0; i < 5; i++) tick(i < 3, 1'b1);
      do_reset("mid");
      send_line(100, 10, 20, 100);
      check("mid_first_rise_newLine", s_nl, 0);
      send_line(100, 10, 20, 100);
      check("mid_second_rise_newLine", s_nl, 1);
      check("mid_line_total", s_lt, 100);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vdc_htiming_detect.md
VDC_HTIMING_DETECT -- requirements
Module: vdc_htiming_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of all position counters and measurement outputs.
REQ-002 SHALL have parameter STABLE_LINES, default 4, number of consecutive matching lines required to assert stable (range 1-15).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  pixel clock enable; inputs are sampled and state advances only on cycles with enable=1.
REQ-006 SHALL have port hsync  input  1  horizontal sync, active high.
REQ-007 SHALL have port hblank  input  1  horizontal blanking, active high.
REQ-008 SHALL have port line_total  output  CNT_W  enable cycles from one hsync rise to the next.
REQ-009 SHALL have port sync_width  output  CNT_W  enable cycles with hsync high in the last line.
REQ-010 SHALL have port back_porch  output  CNT_W  enable cycles from hsync rise to first hblank-low sample.
REQ-011 SHALL have port active_width  output  CNT_W  enable cycles with hblank low in the last line.
REQ-012 SHALL have port newLine  output  1  one-clk pulse when a measurement set is published.
REQ-013 SHALL have ports meas_valid, stable, overflow  output  1 each  status flags.

Function
REQ-014 SHALL keep registered copies hs_d, hb_d of hsync/hblank, updated only on enable cycles; rise = hsync & !hs_d, fall = !hsync & hs_d, hb_fall = !hblank & hb_d, all evaluated only when enable=1.
REQ-015 SHALL implement states SEEK and MEASURE; SEEK -> MEASURE on first rise; MEASURE -> SEEK on overflow; no other transitions except reset.
REQ-016 SHALL, in both states, on rise clear position counter pos to 0; otherwise in MEASURE increment pos by 1 per enable cycle.
REQ-017 SHALL, in MEASURE, count sync-high samples into sw_acc, hblank-low samples into aw_acc, and latch bp_acc = pos+1 at the first hb_fall of the line (hb_fall coinciding with rise gives bp_acc=0).
REQ-018 SHALL, on rise while in MEASURE, publish line_total=pos+1, sync_width=sw_acc, back_porch=bp_acc, active_width=aw_acc in the same clk edge, pulse newLine for exactly one clk, set meas_valid, then clear accumulators (the rise sample itself counts toward the new line's sync_width).
REQ-019 SHALL not publish on the rise that moves SEEK -> MEASURE; first newLine occurs at the second rise.
REQ-020 SHALL publish back_porch=0 when no hb_fall occurred in the line and active_width=0 when hblank stayed high.
REQ-021 SHALL, when pos reaches all-ones without a rise, set overflow, clear meas_valid and stable, return to SEEK; overflow clears at the next published line.
REQ-022 SHALL maintain a match counter: on each publish, if new line_total and sync_width equal the previously published values, increment (saturating at STABLE_LINES); else clear to 0; stable = (match counter == STABLE_LINES).
REQ-023 SHALL hold all state and outputs unchanged on cycles with enable=0, newLine included (newLine is 0 then).
REQ-024 SHALL treat an hsync glitch (rise then fall) as a genuine line boundary; no filtering.

Reset
REQ-025 SHALL, on reset, force state SEEK, pos/accumulators/match counter 0, hs_d=0, hb_d=0, all outputs 0; reset overrides enable and takes effect mid-line, discarding the partial line.

Verification
REQ-026 Line 1024 enable cycles, hsync high 72, hblank high samples 0-159 -> from 2nd rise: line_total=1024, sync_width=72, back_porch=160, active_width=864, newLine once per line.
REQ-027 Same stream, STABLE_LINES=4 -> stable asserts at the 5th newLine; one line of 1016 -> stable drops at that newLine, reasserts 4 matching lines later.
REQ-028 enable=1 every 2nd clk, same stream -> identical values; newLine width exactly 1 clk.
REQ-029 hsync held low 5000 cycles, CNT_W=12 -> overflow=1, meas_valid=0 at pos=4095; next two rises -> overflow=0, valid measurement.
REQ-030 hblank rises/falls coincident with hsync rise -> back_porch=0; hblank never low -> active_width=0, back_porch=0.
REQ-031 reset asserted mid-line after valid lines -> all outputs 0 next clk; first newLine only after two further rises.
